// File: rtl/ifns_decode_sched_if.sv
// ifns_decode_sched_if
// Bundles the lane-side and output-side handshakes of the IFNS decode
// scheduler so they travel as one port.
//   Lane side   : in_valid[N_LANES], in_code[17*N_LANES], in_ready[N_LANES]
//   Output side : out_valid, out_ready, out_value[12], out_lane[LW],
//                 dec_count[16]
// Modports:
//   master - the environment (deserialisers + consumer) driving the block
//   slave  - the scheduler itself
interface ifns_decode_sched_if #(
  parameter int N_LANES = 4,
  parameter int LW      = 3
);
  logic [N_LANES-1:0]    in_valid;
  logic [17*N_LANES-1:0] in_code;
  logic [N_LANES-1:0]    in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [11:0]           out_value;
  logic [LW-1:0]         out_lane;
  logic [15:0]           dec_count;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_value, out_lane, dec_count
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_value, out_lane, dec_count
  );
endinterface

// File: rtl/ifns_decode_sched.sv
// ifns_decode_sched
// Shares one 17-bit -> 12-bit IFNS decoder core between N_LANES receive
// lanes. A round-robin arbiter grants at most one lane per cycle whenever
// the single output stage can accept a word; the granted codeword is muxed
// into the core and its decoded value is registered together with the lane
// index.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - ifns_decode_sched_if.slave: lane valid/code/ready, output
//          valid/ready/value/lane and the accepted-word counter dec_count
module ifns_decode_sched #(
  parameter int N_LANES = 4,
  parameter int LW      = 3
) (
  input logic                clk,
  input logic                rst,
  ifns_decode_sched_if.slave bus
);

  // Weight of codeword bit i (bit 0 = d1). The last weight is 2584, not the
  // Fibonacci continuation, which is how this code family is defined.
  localparam logic [11:0] WEIGHTS [17] = '{
    12'd1,   12'd1,   12'd2,   12'd3,   12'd5,   12'd8,   12'd13,
    12'd21,  12'd34,  12'd55,  12'd89,  12'd144, 12'd233, 12'd377,
    12'd610, 12'd987, 12'd2584
  };

  logic [LW-1:0]      rr_ptr;
  logic [LW-1:0]      grant_idx;
  logic [LW-1:0]      next_ptr;
  logic               grant_any;
  logic [N_LANES-1:0] grant;
  logic               can_load;
  logic [16:0]        core_code;
  logic [11:0]        core_value;
  int                 lane;

  // The output stage can take a new word if it is empty or being drained.
  assign can_load = !bus.out_valid || bus.out_ready;

  // Circular priority search starting at rr_ptr. The first hit wins; the
  // grant_any flag blocks later hits in the same pass.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    lane      = 0;
    if (!rst && can_load) begin
      for (int k = 0; k < N_LANES; k++) begin
        lane = int'(rr_ptr) + k;
        if (lane >= N_LANES) lane = lane - N_LANES;
        if (!grant_any && bus.in_valid[lane]) begin
          grant_any   = 1'b1;
          grant_idx   = LW'(lane);
          grant[lane] = 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = grant;

  // Single shared decoder core fed from the granted lane.
  assign core_code = bus.in_code[17*int'(grant_idx) +: 17];

  always_comb begin
    core_value = '0;
    for (int i = 0; i < 17; i++) begin
      if (core_code[i]) core_value = core_value + WEIGHTS[i];
    end
  end

  assign next_ptr = (grant_idx == LW'(N_LANES - 1)) ? '0 : grant_idx + 1'b1;

  // A grant overrides a drain: the new word replaces the old one with no
  // bubble. Without a grant, a drain only clears out_valid; value and lane
  // keep their last contents.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_value <= '0;
      bus.out_lane  <= '0;
      bus.dec_count <= '0;
      rr_ptr        <= '0;
    end else if (grant_any) begin
      bus.out_valid <= 1'b1;
      bus.out_value <= core_value;
      bus.out_lane  <= grant_idx;
      bus.dec_count <= bus.dec_count + 16'd1;
      rr_ptr        <= next_ptr;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifns_decode_sched.sv
// Self-checking bench for ifns_decode_sched: a behavioural model is compared
// against the DUT on every falling edge, and directed steps pin the model
// with hand-computed literal values.
module tb_ifns_decode_sched;
  localparam int N  = 4;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifns_decode_sched_if #(.N_LANES(N), .LW(LW)) bus ();

  ifns_decode_sched #(.N_LANES(N), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  weights [17] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377,
                        610, 987, 2584};
  bit  m_valid = 1'b0;
  int  m_value = 0;
  int  m_lane  = 0;
  int  m_cnt   = 0;
  int  m_ptr   = 0;
  bit  chk_en  = 1'b0;

  function automatic int decode(input logic [16:0] c);
    int s;
    s = 0;
    for (int i = 0; i < 17; i++) if (c[i]) s += weights[i];
    return s % 4096;
  endfunction

  // Lane that must be granted with the current inputs, or -1.
  function automatic int pick();
    if (rst) return -1;
    if (m_valid && !bus.out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_valid = 1'b0; m_value = 0; m_lane = 0; m_cnt = 0; m_ptr = 0;
    end else begin
      g = pick();
      if (g >= 0) begin
        m_value = decode(bus.in_code[17*g +: 17]);
        m_lane  = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % N;
        m_cnt   = (m_cnt + 1) % 65536;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [31:0] exp_rdy;
    if (chk_en) begin
      g = pick();
      exp_rdy = (g < 0) ? 32'd0 : (32'd1 << g);
      check("m_in_ready",  32'(bus.in_ready),  exp_rdy);
      check("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("m_out_value", 32'(bus.out_value), 32'(m_value));
      check("m_out_lane",  32'(bus.out_lane),  32'(m_lane));
      check("m_dec_count", 32'(bus.dec_count), 32'(m_cnt));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input int l, input logic [16:0] c);
    bus.in_code[17*l +: 17] = c;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_code   = '0;
    bus.out_ready = 1'b1;
    tick();
    chk_en = 1'b1;

    // A lane requesting during reset is not granted.
    bus.in_valid = 4'b0001;
    set_code(0, 17'h10000);
    #1 check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;

    // Lane 0, d17 only.
    #1 check("d17_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = '0;
    check("d17_valid", 32'(bus.out_valid), 32'h1);
    check("d17_value", 32'(bus.out_value), 32'd2584);
    check("d17_lane",  32'(bus.out_lane),  32'd0);
    check("d17_count", 32'(bus.dec_count), 32'd1);

    // Lane 2, all ones: 5167 mod 4096.
    set_code(2, 17'h1FFFF);
    bus.in_valid = 4'b0100;
    tick();
    bus.in_valid = '0;
    check("ones_value", 32'(bus.out_value), 32'd1071);
    check("ones_lane",  32'(bus.out_lane),  32'd2);
    check("ones_count", 32'(bus.dec_count), 32'd2);

    // Fairness from a fresh pointer: all lanes valid for 8 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int l = 0; l < N; l++) set_code(l, 17'h08001);
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 check("rr_in_ready", 32'(bus.in_ready), 32'd1 << (i % 4));
      tick();
      check("rr_lane",  32'(bus.out_lane),  32'(i % 4));
      check("rr_value", 32'(bus.out_value), 32'd988);
    end
    check("rr_count", 32'(bus.dec_count), 32'd8);

    // Load one word from lane 0 (pointer moves to 1), then backpressure.
    bus.in_valid = 4'b0001;
    tick();
    bus.out_ready = 1'b0;
    set_code(1, 17'h00003);
    set_code(3, 17'h00010);
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check("bp_valid", 32'(bus.out_valid), 32'h1);
      check("bp_value", 32'(bus.out_value), 32'd988);
      check("bp_lane",  32'(bus.out_lane),  32'd0);
    end
    // Drain and grant lane 1 in the same cycle.
    bus.out_ready = 1'b1;
    #1 check("drain_in_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    bus.in_valid = 4'b1000;
    check("drain_valid", 32'(bus.out_valid), 32'h1);
    check("drain_lane",  32'(bus.out_lane),  32'd1);
    check("drain_value", 32'(bus.out_value), 32'd2);
    tick();
    check("l3_lane",  32'(bus.out_lane),  32'd3);
    check("l3_value", 32'(bus.out_value), 32'd5);
    check("l3_count", 32'(bus.dec_count), 32'd11);

    // Reset mid-operation with lanes requesting.
    bus.in_valid = 4'b1111;
    rst = 1'b1;
    #1 check("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_count", 32'(bus.dec_count), 32'h0);
    #1 check("mid_rst_first", 32'(bus.in_ready), 32'h1);

    // Counter wrap.
    repeat (65535) tick();
    check("wrap_pre",  32'(bus.dec_count), 32'hFFFF);
    tick();
    check("wrap_post", 32'(bus.dec_count), 32'h0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ifns_decode_sched.md
# ifns_decode_sched

Round-robin scheduler that shares one 17-bit-to-12-bit IFNS decoder core between `N_LANES` receive lanes of a CAC-coded bus. Each lane presents a codeword with a valid/ready handshake. The scheduler grants one lane per cycle, drives the core, and registers the 12-bit result with its lane index into a single output stage that has its own valid/ready handshake. The block sits between the per-lane deserialisers and the downstream word consumer.

## Interface
Parameters:
- `N_LANES`, 4: number of requesting lanes, 2..8.
- `LW`, 3: lane-index width; must satisfy 2^LW >= `N_LANES`.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  `N_LANES`  bit i: lane i presents a codeword.
- `in_code`  in  17*`N_LANES`  lane i codeword at [17i+16:17i]; bit 17i is d1 and bit 17i+16 is d17.
- `in_ready`  out  `N_LANES`  bit i: lane i codeword accepted this cycle (one-hot or zero).
- `out_valid`  out  1  output stage holds a decoded word.
- `out_ready`  in  1  consumer accepts the output word.
- `out_value`  out  12  decoded value.
- `out_lane`  out  `LW`  lane that produced `out_value`.
- `dec_count`  out  16  total accepted codewords, wraps modulo 2^16.

## Operation
- Decode weights for d1..d17: 1,1,2,3,5,8,13,21,34,55,89,144,233,377,610,987,2584. The value is the weighted sum truncated to 12 bits (mod 4096). The block uses exactly one core instance; the arithmetic is not duplicated per lane.
- `can_load = !out_valid || out_ready`.
- Arbitration: when `can_load` is high, grant the first lane with `in_valid` set, searching circularly from `rr_ptr` upward. `in_ready` is the one-hot grant. It is combinational and depends on `in_valid`, `out_valid` and `out_ready`. When `can_load` is low, `in_ready` is 0.
- The core input is muxed from the granted lane. On grant, at the clock edge:
  - `out_value`, `out_lane` and `out_valid` (set to 1) load.
  - `rr_ptr` becomes (granted+1) mod `N_LANES`.
  - `dec_count` increments.
- Drain without a new grant (`out_valid && out_ready`, no lane valid): `out_valid` goes to 0. `out_value` and `out_lane` hold their last values.
- Simultaneous drain and grant: the new word replaces the old one, `out_valid` stays 1, and there is no bubble.
- With no grant, `rr_ptr` holds.
- Codeword legality is not checked; any 17-bit pattern decodes by the weight rule.
- Lanes must hold `in_valid` and `in_code` stable until granted. The block does not store un-granted codewords.

## Timing
- Reset values: `out_valid`=0, `out_value`=0, `out_lane`=0, `dec_count`=0, `rr_ptr`=0 (lane 0 has highest priority). `in_ready` is 0 during the reset cycle.
- Reset mid-operation: the output word is discarded, with no `out_valid` in the following cycle. A lane asserting valid during reset is not granted.
- Latency: a codeword granted in cycle n appears on `out_value`/`out_lane` with `out_valid`=1 in cycle n+1.
- Throughput: one word per cycle while `out_ready`=1.
- Backpressure: while `out_valid`=1 and `out_ready`=0, outputs hold stable and all `in_ready` bits are 0.
- Fairness: with all lanes continuously valid and `out_ready`=1, the grants cycle 0,1,..,N-1,0,… Every requesting lane is granted within `N_LANES` grant cycles.
- `dec_count` wraps from 0xFFFF to 0x0000.

## Test plan
- Reset, then lane 0 only with code 0x10000 (d17 only) -> `in_ready`=0001 in that cycle; next cycle `out_valid`=1, `out_value`=2584 (0xA18), `out_lane`=0, `dec_count`=1.
- Lane 2 with code 0x1FFFF (all ones) -> `out_value`=1071 (5167 mod 4096), `out_lane`=2.
- All four lanes valid, `out_ready`=1 for 8 cycles, lane i code = 0x08001 (d16+d1) -> grants 0,1,2,3,0,1,2,3; every `out_value`=988; `dec_count`=8.
- Output word pending and `out_ready`=0 for 5 cycles with lanes 1 and 3 valid -> `in_ready`=0 throughout and outputs stable. Raising `out_ready` grants lane 1 (the pointer was at 1) in the same cycle as the drain, with no bubble.
- `rst` asserted for one cycle while `out_valid`=1 and lanes are requesting -> the next cycle shows `out_valid`=0, `dec_count`=0, and lane 0 wins first.
- Preload 65535 accepts (or force the counter) and then one more accept -> `dec_count`=0.
